ov5640_capture_ctrl: RTL and testbench

Frame-level capture controller in the `ov5640_pclk` domain, sitting between the OV5640 sync signals and the byte-to-pixel assembler that feeds the SDRAM write FIFO. It discards the sensor's settling frames after reset and arms capture on request, in single-shot or continuous mode. It gates the assembler's write path to whole frames only, tracks pixel/line coordinates for the address generator, and flags frames whose geometry does not match the configured resolution.

---
 rtl/ov5640_capture_ctrl_if.sv | 36 +++
 rtl/ov5640_capture_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ov5640_capture_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ov5640_capture_ctrl_if.sv
// ov5640_capture_ctrl_if: sync/handshake bundle around the frame capture controller.
//   master : sensor sync + assembler pulse + capture control (drives inputs, sees status)
//   slave  : the capture controller itself
// Signals:
//   vsync, href      sensor frame/line sync
//   pix_wr_en        one pulse per assembled 16-bit pixel
//   cap_start/single/stop  capture control
//   cap_gate, busy   write-path enable, controller not idle
//   frame_start/done/err   one-cycle frame event pulses
//   pix_x, pix_y     pixel/line coordinates, frame_cnt good-frame count
interface ov5640_capture_ctrl_if;
  logic        vsync;
  logic        href;
  logic        pix_wr_en;
  logic        cap_start;
  logic        cap_single;
  logic        cap_stop;
  logic        cap_gate;
  logic        busy;
  logic        frame_start;
  logic        frame_done;
  logic        frame_err;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [7:0]  frame_cnt;

  modport master (
    output vsync, href, pix_wr_en, cap_start, cap_single, cap_stop,
    input  cap_gate, busy, frame_start, frame_done, frame_err, pix_x, pix_y, frame_cnt
  );

  modport slave (
    input  vsync, href, pix_wr_en, cap_start, cap_single, cap_stop,
    output cap_gate, busy, frame_start, frame_done, frame_err, pix_x, pix_y, frame_cnt
  );
endinterface

// File: rtl/ov5640_capture_ctrl.sv
// ov5640_capture_ctrl: frame-level capture controller in the ov5640_pclk domain.
// Drops the sensor's settling frames after reset, then gates the assembler write
// path to whole frames (single-shot or continuous), tracks pixel/line coordinates
// and reports each closed frame as good (frame_done) or wrong geometry (frame_err).
// Ports:
//   ov5640_pclk  sensor pixel clock, rising edge
//   s_rst_n      asynchronous active-low reset
//   bus          ov5640_capture_ctrl_if.slave (sync inputs, control, status outputs)
module ov5640_capture_ctrl #(
  parameter int unsigned H_PIXELS    = 640,
  parameter int unsigned V_LINES     = 480,
  parameter int unsigned SKIP_FRAMES = 10
) (
  input  logic                        ov5640_pclk,
  input  logic                        s_rst_n,
  ov5640_capture_ctrl_if.slave        bus
);

  // Counter only needs to hold 0..SKIP_FRAMES-1; the final edge exits SKIP.
  localparam int unsigned SkipW = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
  localparam logic [SkipW-1:0] SkipLast = SkipW'(SKIP_FRAMES - 1);
  localparam logic [12:0] HLen = 13'(H_PIXELS);
  localparam logic [11:0] VLen = 12'(V_LINES);
  localparam logic [11:0] CoordMax = 12'hFFF;

  typedef enum logic [1:0] {StIdle, StSkip, StWaitVs, StActive} state_e;

  state_e           state_q;
  logic             vsync_r, href_r;
  logic [SkipW-1:0] skip_cnt_q;
  logic             skip_done_q;
  logic             mode_single_q;
  logic             stop_pend_q;
  logic             line_err_q;
  logic             cap_gate_q, busy_q;
  logic             frame_start_q, frame_done_q, frame_err_q;
  logic [11:0]      pix_x_q, pix_y_q;
  logic [7:0]       frame_cnt_q;

  logic        vs_pos, hs_neg, frame_good;
  logic [12:0] line_len;

  assign vs_pos     = bus.vsync & ~vsync_r;
  assign hs_neg     = href_r & ~bus.href;
  // A pixel pulse coinciding with the falling href still belongs to this line.
  assign line_len   = {1'b0, pix_x_q} + {12'd0, bus.pix_wr_en};
  assign frame_good = (pix_y_q == VLen) && !line_err_q;

  always_ff @(posedge ov5640_pclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q       <= StIdle;
      vsync_r       <= 1'b0;
      href_r        <= 1'b0;
      skip_cnt_q    <= '0;
      skip_done_q   <= 1'b0;
      mode_single_q <= 1'b0;
      stop_pend_q   <= 1'b0;
      line_err_q    <= 1'b0;
      cap_gate_q    <= 1'b0;
      busy_q        <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_cnt_q   <= '0;
    end else begin
      vsync_r       <= bus.vsync;
      href_r        <= bus.href;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;

      case (state_q)
        StIdle: begin
          if (bus.cap_start) begin
            mode_single_q <= bus.cap_single;
            busy_q        <= 1'b1;
            if (!skip_done_q) begin
              state_q    <= StSkip;
              skip_cnt_q <= '0;
            end else begin
              state_q <= StWaitVs;
            end
          end
        end

        StSkip: begin
          if (bus.cap_stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (vs_pos) begin
            if (skip_cnt_q == SkipLast) begin
              skip_done_q   <= 1'b1;
              state_q       <= StActive;
              cap_gate_q    <= 1'b1;
              frame_start_q <= 1'b1;
              pix_x_q       <= '0;
              pix_y_q       <= '0;
              line_err_q    <= 1'b0;
            end else begin
              skip_cnt_q <= skip_cnt_q + SkipW'(1);
            end
          end
        end

        StWaitVs: begin
          if (bus.cap_stop) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (vs_pos) begin
            state_q       <= StActive;
            cap_gate_q    <= 1'b1;
            frame_start_q <= 1'b1;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            line_err_q    <= 1'b0;
          end
        end

        StActive: begin
          if (vs_pos) begin
            // Frame close; any pixel pulse on this edge is dropped.
            if (frame_good) begin
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 8'd1;
            end else begin
              frame_err_q <= 1'b1;
            end
            if (mode_single_q || stop_pend_q || bus.cap_stop) begin
              state_q     <= StIdle;
              cap_gate_q  <= 1'b0;
              busy_q      <= 1'b0;
              stop_pend_q <= 1'b0;
            end else begin
              frame_start_q <= 1'b1;
              pix_x_q       <= '0;
              pix_y_q       <= '0;
              line_err_q    <= 1'b0;
            end
          end else begin
            if (bus.cap_stop) begin
              stop_pend_q <= 1'b1;
            end
            if (hs_neg) begin
              if (line_len != HLen) begin
                line_err_q <= 1'b1;
              end
              pix_x_q <= '0;
              if (pix_y_q != CoordMax) begin
                pix_y_q <= pix_y_q + 12'd1;
              end
            end else if (bus.pix_wr_en && (pix_x_q != CoordMax)) begin
              pix_x_q <= pix_x_q + 12'd1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.cap_gate    = cap_gate_q;
  assign bus.busy        = busy_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ov5640_capture_ctrl.sv
// tb_ov5640_capture_ctrl: directed bench for ov5640_capture_ctrl with a small
// geometry (4 pixels x 2 lines, 2 skipped frames). A cycle-by-cycle vector table
// covers the single-shot path; hand-written sequences cover continuous capture,
// bad geometry, stop handling and asynchronous reset.
module tb_ov5640_capture_ctrl;

  logic ov5640_pclk = 1'b0;
  logic s_rst_n     = 1'b0;

  always #5 ov5640_pclk = ~ov5640_pclk;

  ov5640_capture_ctrl_if bus ();

  ov5640_capture_ctrl #(
    .H_PIXELS    (4),
    .V_LINES     (2),
    .SKIP_FRAMES (2)
  ) dut (
    .ov5640_pclk (ov5640_pclk),
    .s_rst_n     (s_rst_n),
    .bus         (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  int gate_gap = 0;
  int fs_idle  = 0;
  bit gate_watch = 1'b0;

  // Inputs packed as {vsync, href, pix_wr_en, cap_start, cap_single, cap_stop};
  // expected as {gate, busy, frame_start, frame_done, frame_err, pix_x, pix_y, frame_cnt}.
  typedef struct packed {
    logic [5:0]  in;
    logic [36:0] exp;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic [5:0] in, input logic [4:0] fl,
                              input logic [11:0] x, input logic [11:0] y,
                              input logic [7:0] c);
    vec_t v;
    v.in  = in;
    v.exp = {fl, x, y, c};
    return v;
  endfunction

  function automatic logic [36:0] outs();
    return {bus.cap_gate, bus.busy, bus.frame_start, bus.frame_done, bus.frame_err,
            bus.pix_x, bus.pix_y, bus.frame_cnt};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Apply inputs, let one rising edge sample them, return at the next falling edge.
  task automatic step(input logic [5:0] in);
    {bus.vsync, bus.href, bus.pix_wr_en, bus.cap_start, bus.cap_single, bus.cap_stop} = in;
    @(negedge ov5640_pclk);
  endtask

  // n pixels; on_fall places the last pixel pulse on the href falling cycle.
  task automatic line(input int n, input bit on_fall);
    if (on_fall) begin
      for (int i = 0; i < n - 1; i++) step(6'b011000);
      step(6'b001000);
    end else begin
      for (int i = 0; i < n; i++) step(6'b011000);
      step(6'b000000);
    end
    step(6'b000000);
  endtask

  task automatic good_frame();
    line(4, 1'b0);
    line(4, 1'b1);
  endtask

  // vsync rising edge with optional stop; fl = {gate, busy, fs, fd, fe}.
  task automatic vs_close(input string name, input logic sp, input logic [4:0] fl,
                          input logic [7:0] c);
    step({5'b10000, sp});
    chk(name, {51'd0, bus.cap_gate, bus.busy, bus.frame_start, bus.frame_done,
               bus.frame_err, bus.frame_cnt}, {51'd0, fl, c});
    step(6'b000000);
    chk({name, "_pulse_end"}, {61'd0, bus.frame_start, bus.frame_done, bus.frame_err},
        64'd0);
  endtask

  task automatic do_reset();
    {bus.vsync, bus.href, bus.pix_wr_en, bus.cap_start, bus.cap_single, bus.cap_stop} = '0;
    s_rst_n = 1'b0;
    @(negedge ov5640_pclk);
    @(negedge ov5640_pclk);
    s_rst_n = 1'b1;
  endtask

  always @(negedge ov5640_pclk) begin
    if (gate_watch && !bus.cap_gate) gate_gap++;
    if (bus.frame_start && !bus.busy) fs_idle++;
  end

  initial begin
    // Single-shot: start, two skipped vsync edges, one 2x4 frame, close.
    vecs[0]  = mk(6'b000110, 5'b01000, 12'd0, 12'd0, 8'd0);
    vecs[1]  = mk(6'b100000, 5'b01000, 12'd0, 12'd0, 8'd0);
    vecs[2]  = mk(6'b000000, 5'b01000, 12'd0, 12'd0, 8'd0);
    vecs[3]  = mk(6'b100000, 5'b11100, 12'd0, 12'd0, 8'd0);
    vecs[4]  = mk(6'b011000, 5'b11000, 12'd1, 12'd0, 8'd0);
    vecs[5]  = mk(6'b011000, 5'b11000, 12'd2, 12'd0, 8'd0);
    vecs[6]  = mk(6'b011000, 5'b11000, 12'd3, 12'd0, 8'd0);
    vecs[7]  = mk(6'b001000, 5'b11000, 12'd0, 12'd1, 8'd0);
    vecs[8]  = mk(6'b011000, 5'b11000, 12'd1, 12'd1, 8'd0);
    vecs[9]  = mk(6'b011000, 5'b11000, 12'd2, 12'd1, 8'd0);
    vecs[10] = mk(6'b011000, 5'b11000, 12'd3, 12'd1, 8'd0);
    vecs[11] = mk(6'b011000, 5'b11000, 12'd4, 12'd1, 8'd0);
    vecs[12] = mk(6'b000000, 5'b11000, 12'd0, 12'd2, 8'd0);
    vecs[13] = mk(6'b101000, 5'b00010, 12'd0, 12'd2, 8'd1);
    vecs[14] = mk(6'b000000, 5'b00000, 12'd0, 12'd2, 8'd1);
    vecs[15] = mk(6'b100000, 5'b00000, 12'd0, 12'd2, 8'd1);

    do_reset();
    chk("reset_state", {27'd0, outs()}, 64'd0);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].in);
      chk($sformatf("vec%0d", i), {27'd0, outs()}, {27'd0, vecs[i].exp});
    end

    // Continuous: fresh reset re-skips, then four good frames back to back.
    do_reset();
    step(6'b000100);
    chk("s2_arm_busy", {62'd0, bus.busy, bus.cap_gate}, 64'd2);
    vs_close("s2_skip1", 1'b0, 5'b01000, 8'd0);
    vs_close("s2_skip2", 1'b0, 5'b11100, 8'd0);
    gate_watch = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      good_frame();
      vs_close($sformatf("s2_frame%0d", k), 1'b0, 5'b11110, 8'(k));
    end

    // Short line gives frame_err and no count; the next good frame recovers.
    line(3, 1'b0);
    line(4, 1'b0);
    vs_close("s3_err", 1'b0, 5'b11101, 8'd4);
    good_frame();
    vs_close("s3_recover", 1'b0, 5'b11110, 8'd5);

    // Stop mid-frame: frame completes, then IDLE; re-arm skips straight to WAIT_VS.
    line(4, 1'b0);
    chk("s4_pix_y", {52'd0, bus.pix_y}, 64'd1);
    step(6'b000001);
    line(4, 1'b1);
    gate_watch = 1'b0;
    vs_close("s4_close", 1'b0, 5'b00010, 8'd6);
    step(6'b000100);
    chk("s4_rearm_busy", {62'd0, bus.busy, bus.cap_gate}, 64'd2);
    vs_close("s4_rearm_vs", 1'b0, 5'b11100, 8'd6);

    // Stop coinciding with the closing vsync edge.
    good_frame();
    vs_close("s5_stop_on_vs", 1'b1, 5'b00010, 8'd7);

    // Asynchronous reset mid-frame, then the skip must repeat.
    step(6'b000100);
    vs_close("s6_open", 1'b0, 5'b11100, 8'd7);
    line(4, 1'b0);
    step(6'b011000);
    step(6'b011000);
    #2 s_rst_n = 1'b0;
    #1 chk("s6_async_reset", {27'd0, outs()}, 64'd0);
    {bus.vsync, bus.href, bus.pix_wr_en, bus.cap_start, bus.cap_single, bus.cap_stop} = '0;
    @(negedge ov5640_pclk);
    s_rst_n = 1'b1;
    step(6'b000100);
    chk("s6_arm_busy", {62'd0, bus.busy, bus.cap_gate}, 64'd2);
    vs_close("s6_skip1", 1'b0, 5'b01000, 8'd0);
    vs_close("s6_skip2", 1'b0, 5'b11100, 8'd0);
    good_frame();
    vs_close("s6_frame", 1'b0, 5'b11110, 8'd1);

    chk("gate_continuous", 64'(gate_gap), 64'd0);
    chk("no_start_in_idle", 64'(fs_idle), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
